mem_arbiter_rr: RTL and testbench

MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

---
 rtl/mem_arbiter_rr.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-master to single-slave memory bus arbiter.
// Fixed-priority or round-robin selection, one transfer per grant,
// with an optional watchdog that force-acks a stalled transfer.
module mem_arbiter_rr #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 16,
  parameter int MODE      = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_MASTERS-1:0]             m_access,
  input  logic [N_MASTERS*ADDR_W-1:0]      m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]      m_data_out,
  input  logic [N_MASTERS-1:0]             m_wr_en,
  input  logic [N_MASTERS*(DATA_W/8)-1:0]  m_bytesel,
  output logic [N_MASTERS*DATA_W-1:0]      m_data_in,
  output logic [N_MASTERS-1:0]             m_ack,
  output logic                             s_access,
  output logic [ADDR_W-1:0]                s_addr,
  output logic [DATA_W-1:0]                s_data_out,
  output logic                             s_wr_en,
  output logic [(DATA_W/8)-1:0]            s_bytesel,
  input  logic [DATA_W-1:0]                s_data_in,
  input  logic                             s_ack,
  output logic                             timeout_err
);

  localparam int          BSEL_W   = DATA_W / 8;
  localparam int unsigned NM       = N_MASTERS;
  localparam int          GW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int          CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [GW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   winner;
  logic            found;
  logic [GW-1:0]   rr_start;
  logic            req_g;
  logic            in_grant;
  logic            timeout_hit;
  logic            done;

  assign in_grant = (state_q == GRANT);

  // Winner selection: lowest index, or first requester at/after rr_start.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    rr_start = (last_q == GW'(NM - 1)) ? '0 : last_q + GW'(1);
    if (MODE == 1) begin
      for (int unsigned k = 0; k < NM; k++) begin
        int unsigned cand;
        cand = 32'(rr_start) + k;
        if (cand >= NM) cand = cand - NM;
        for (int unsigned i = 0; i < NM; i++) begin
          if (!found && (cand == i) && m_access[i]) begin
            winner = GW'(i);
            found  = 1'b1;
          end
        end
      end
    end else begin
      for (int unsigned i = 0; i < NM; i++) begin
        if (!found && m_access[i]) begin
          winner = GW'(i);
          found  = 1'b1;
        end
      end
    end
  end

  // Slave bus mux from the granted master; all zero outside GRANT.
  always_comb begin
    req_g      = 1'b0;
    s_addr     = '0;
    s_data_out = '0;
    s_wr_en    = 1'b0;
    s_bytesel  = '0;
    if (in_grant) begin
      for (int unsigned i = 0; i < NM; i++) begin
        if (g_q == GW'(i)) begin
          req_g      = m_access[i];
          s_addr     = m_addr[i*ADDR_W +: ADDR_W];
          s_data_out = m_data_out[i*DATA_W +: DATA_W];
          s_wr_en    = m_wr_en[i];
          s_bytesel  = m_bytesel[i*BSEL_W +: BSEL_W];
        end
      end
    end
  end

  // Watchdog fires on the last counted cycle only if the slave stays silent.
  always_comb begin
    timeout_hit = (TIMEOUT > 0) && in_grant && req_g && !s_ack && (cnt_q == CNT_LAST);
    done        = in_grant && (s_ack || timeout_hit);
    s_access    = in_grant && req_g && !s_ack && !timeout_hit;
    timeout_err = timeout_hit;
  end

  // Ack and read-data return to the granted master only in its completion cycle.
  always_comb begin
    m_ack     = '0;
    m_data_in = '0;
    if (done) begin
      for (int unsigned i = 0; i < NM; i++) begin
        if (g_q == GW'(i)) begin
          m_ack[i] = 1'b1;
          m_data_in[i*DATA_W +: DATA_W] = timeout_hit ? {DATA_W{1'b1}} : s_data_in;
        end
      end
    end
  end

  // Next-state: arbitrate in IDLE; leave GRANT on ack, timeout or abort.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|m_access) begin
          state_d = GRANT;
          g_d     = winner;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + CW'(1);
        if (done) begin
          // Only finished transfers move the rotation; aborts leave it alone.
          state_d = IDLE;
          last_d  = g_q;
        end else if (!req_g) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset puts master 0 first in the rotation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= GW'(NM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed checks of mem_arbiter_rr in fixed-priority
// (2 masters, TIMEOUT=4) and round-robin (3 masters) configurations.
module tb_mem_arbiter_rr;

  logic clk;
  logic rst;

  // dut0: MODE 0, 2 masters, TIMEOUT 4
  logic [1:0]  a0_acc;
  logic [37:0] a0_addr;
  logic [31:0] a0_wdat;
  logic [1:0]  a0_we;
  logic [3:0]  a0_bs;
  logic [31:0] a0_rdat;
  logic [1:0]  a0_ack;
  logic        s0_acc;
  logic [18:0] s0_addr;
  logic [15:0] s0_wdat;
  logic        s0_we;
  logic [1:0]  s0_bs;
  logic [15:0] s0_rdat;
  logic        s0_ack;
  logic        to0;
  logic        sl0_en;

  // dut1: MODE 1, 3 masters
  logic [2:0]  a1_acc;
  logic [56:0] a1_addr;
  logic [47:0] a1_wdat;
  logic [2:0]  a1_we;
  logic [5:0]  a1_bs;
  logic [47:0] a1_rdat;
  logic [2:0]  a1_ack;
  logic        s1_acc;
  logic [18:0] s1_addr;
  logic [15:0] s1_wdat;
  logic        s1_we;
  logic [1:0]  s1_bs;
  logic [15:0] s1_rdat;
  logic        s1_ack;
  logic        to1;
  logic        sl1_en;

  int n_chk;
  int n_err;

  mem_arbiter_rr #(.N_MASTERS(2), .ADDR_W(19), .DATA_W(16), .MODE(0), .TIMEOUT(4)) dut0 (
    .clk(clk), .reset(rst),
    .m_access(a0_acc), .m_addr(a0_addr), .m_data_out(a0_wdat), .m_wr_en(a0_we),
    .m_bytesel(a0_bs), .m_data_in(a0_rdat), .m_ack(a0_ack),
    .s_access(s0_acc), .s_addr(s0_addr), .s_data_out(s0_wdat), .s_wr_en(s0_we),
    .s_bytesel(s0_bs), .s_data_in(s0_rdat), .s_ack(s0_ack), .timeout_err(to0)
  );

  mem_arbiter_rr #(.N_MASTERS(3), .ADDR_W(19), .DATA_W(16), .MODE(1), .TIMEOUT(64)) dut1 (
    .clk(clk), .reset(rst),
    .m_access(a1_acc), .m_addr(a1_addr), .m_data_out(a1_wdat), .m_wr_en(a1_we),
    .m_bytesel(a1_bs), .m_data_in(a1_rdat), .m_ack(a1_ack),
    .s_access(s1_acc), .s_addr(s1_addr), .s_data_out(s1_wdat), .s_wr_en(s1_we),
    .s_bytesel(s1_bs), .s_data_in(s1_rdat), .s_ack(s1_ack), .timeout_err(to1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered slaves: ack one cycle after seeing s_access (when enabled).
  always @(posedge clk or posedge rst) begin
    if (rst) s0_ack <= 1'b0;
    else     s0_ack <= s0_acc & sl0_en;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) s1_ack <= 1'b0;
    else     s1_ack <= s1_acc & sl1_en;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  rr_ack [4];
  logic [47:0] rr_dat [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b0;
    a0_acc = '0; a0_addr = '0; a0_wdat = '0; a0_we = '0; a0_bs = '0;
    a1_acc = '0; a1_addr = '0; a1_wdat = '0; a1_we = '0; a1_bs = '0;
    sl0_en = 1'b1; sl1_en = 1'b1;
    s0_rdat = 16'hA5A5; s1_rdat = 16'h3C3C;
    rr_ack[0] = 3'b001; rr_ack[1] = 3'b010; rr_ack[2] = 3'b100; rr_ack[3] = 3'b001;
    rr_dat[0] = 48'h0000_0000_3C3C; rr_dat[1] = 48'h0000_3C3C_0000;
    rr_dat[2] = 48'h3C3C_0000_0000; rr_dat[3] = 48'h0000_0000_3C3C;

    #1 rst = 1'b1;
    #1;
    chk("rst s0_access", s0_acc, 0);
    chk("rst m_ack0", a0_ack, 0);
    chk("rst timeout0", to0, 0);
    chk("rst m_data_in0", a0_rdat, 0);
    chk("rst s1_access", s1_acc, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    a0_addr = {19'h00020, 19'h00010};
    a1_addr = {19'h00300, 19'h00200, 19'h00100};

    // Fixed priority: both request, master 0 first, master 1 after idle gap
    tick(); a0_acc = 2'b11; #1;
    chk("A latency idle", s0_acc, 0);
    tick(); #1;
    chk("A grant0 s_access", s0_acc, 1);
    chk("A grant0 s_addr", s0_addr, 19'h00010);
    chk("A grant0 no ack yet", a0_ack, 0);
    tick(); #1;
    chk("A ack0", a0_ack, 2'b01);
    chk("A ack0 data", a0_rdat, 32'h0000_A5A5);
    chk("A ack cycle s_access", s0_acc, 0);
    tick(); a0_acc = 2'b10; #1;
    chk("A idle gap s_access", s0_acc, 0);
    chk("A idle gap m_ack", a0_ack, 0);
    tick(); #1;
    chk("A grant1 s_access", s0_acc, 1);
    chk("A grant1 s_addr", s0_addr, 19'h00020);
    tick(); #1;
    chk("A ack1", a0_ack, 2'b10);
    chk("A ack1 data", a0_rdat, 32'hA5A5_0000);
    tick(); a0_acc = 2'b00; #1;
    chk("A post ack", a0_ack, 0);

    // Write from master 1 routed verbatim onto the slave bus
    tick();
    a0_addr = {19'h01234, 19'h00777};
    a0_wdat = {16'hBEEF, 16'h5555};
    a0_we = 2'b10; a0_bs = 4'b1001; a0_acc = 2'b10;
    #1;
    chk("B idle s_access", s0_acc, 0);
    tick(); #1;
    chk("B s_access", s0_acc, 1);
    chk("B s_addr", s0_addr, 19'h01234);
    chk("B s_data_out", s0_wdat, 16'hBEEF);
    chk("B s_wr_en", s0_we, 1);
    chk("B s_bytesel", s0_bs, 2'b10);
    chk("B no early ack", a0_ack, 0);
    tick(); #1;
    chk("B ack1", a0_ack, 2'b10);
    tick(); a0_acc = 2'b00; a0_we = 2'b00; #1;
    chk("B single pulse", a0_ack, 0);
    chk("B idle s_wr_en", s0_we, 0);
    chk("B idle s_bytesel", s0_bs, 0);

    // Timeout: silent slave, force-ack in 4th GRANT cycle
    tick(); sl0_en = 1'b0; s0_rdat = 16'h1357; a0_acc = 2'b01;
    tick(); #1;
    chk("C grant s_access", s0_acc, 1);
    chk("C grant timeout_err", to0, 0);
    tick(); tick(); #1;
    chk("C cycle3 s_access", s0_acc, 1);
    chk("C cycle3 timeout_err", to0, 0);
    chk("C cycle3 m_ack", a0_ack, 0);
    tick(); #1;
    chk("C timeout_err", to0, 1);
    chk("C forced ack", a0_ack, 2'b01);
    chk("C forced data", a0_rdat, 32'h0000_FFFF);
    chk("C timeout s_access", s0_acc, 0);
    tick(); a0_acc = 2'b00; sl0_en = 1'b1; #1;
    chk("C after timeout_err", to0, 0);
    chk("C after m_ack", a0_ack, 0);

    // Round robin, all three held requesting: 0,1,2,0
    tick(); a1_acc = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick(); tick(); #1;
      chk($sformatf("D rr ack %0d", k), a1_ack, rr_ack[k]);
      chk($sformatf("D rr data %0d", k), a1_rdat, rr_dat[k]);
      tick(); #1;
      chk($sformatf("D rr gap %0d", k), s1_acc, 0);
    end

    // Reset in the middle of a grant on both arbiters
    a0_acc = 2'b10;
    tick(); #1;
    chk("E pre s0_access", s0_acc, 1);
    chk("E pre s0_addr", s0_addr, 19'h01234);
    chk("E pre s1_access", s1_acc, 1);
    chk("E pre s1_addr", s1_addr, 19'h00200);
    #1 rst = 1'b1;
    #1;
    chk("E async s0_access", s0_acc, 0);
    chk("E async s1_access", s1_acc, 0);
    chk("E async m_ack0", a0_ack, 0);
    chk("E async m_ack1", a1_ack, 0);
    tick(); #1;
    chk("E held m_ack0", a0_ack, 0);
    chk("E held m_ack1", a1_ack, 0);
    rst = 1'b0; a0_acc = 2'b11;
    tick(); #1;
    chk("E rel s0_addr m0", s0_addr, 19'h00777);
    chk("E rel s1_addr m0", s1_addr, 19'h00100);
    tick(); #1;
    chk("E rel ack0", a0_ack, 2'b01);
    chk("E rel ack1", a1_ack, 3'b001);

    // Abort by master 1 must not move the round-robin pointer
    tick(); a0_acc = 2'b00; a1_acc = 3'b010; sl1_en = 1'b0; #1;
    chk("F idle m_ack", a1_ack, 0);
    tick(); #1;
    chk("F grant s_access", s1_acc, 1);
    chk("F grant s_addr", s1_addr, 19'h00200);
    tick(); a1_acc = 3'b000; #1;
    chk("F abort s_access", s1_acc, 0);
    chk("F abort m_ack", a1_ack, 0);
    tick(); a1_acc = 3'b111; sl1_en = 1'b1; #1;
    chk("F back idle s_access", s1_acc, 0);
    chk("F back idle m_ack", a1_ack, 0);
    tick(); #1;
    chk("F regrant s_access", s1_acc, 1);
    chk("F regrant master1", s1_addr, 19'h00200);
    tick(); #1;
    chk("F regrant ack", a1_ack, 3'b010);
    tick(); a1_acc = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
